if_stage: RTL and testbench



---
 rtl/if_stage_if.sv | 31 +++
 rtl/if_stage.sv | 57 +++++
 tb/tb_if_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bus: EX/ID redirect inputs, memory read ports, IF outputs
interface if_stage_if #(
    parameter int BIOS_AW = 12,
    parameter int IMEM_AW = 14
);
    logic               ex_stall;
    logic               ex_flush;
    logic [31:0]        ex_target;
    logic               id_target_taken;
    logic [31:0]        id_pc_target;
    logic [31:0]        fetch_pc;
    logic               bios_en;
    logic [BIOS_AW-1:0] bios_addr;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        if_pc;
    logic               if_valid;
    logic [31:0]        if_fetch_cnt;

    modport master (
        input  ex_stall, ex_flush, ex_target, id_target_taken, id_pc_target,
        output fetch_pc, bios_en, bios_addr, imem_en, imem_addr,
               if_pc, if_valid, if_fetch_cnt
    );

    modport slave (
        output ex_stall, ex_flush, ex_target, id_target_taken, id_pc_target,
        input  fetch_pc, bios_en, bios_addr, imem_en, imem_addr,
               if_pc, if_valid, if_fetch_cnt
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC register, next-PC arbitration, boot sequence, fetch counter
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          BIOS_AW  = 12,
    parameter int          IMEM_AW  = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    if_stage_if.master bus
);
    typedef enum logic {BOOT, RUN} state_t;

    state_t      state;
    logic [31:0] next_pc;

    // Strict priority: flush > stall > ID redirect > sequential. BOOT ignores all of them.
    always_comb begin
        next_pc = bus.if_pc + 32'd4;
        if (state == BOOT)
            next_pc = RESET_PC;
        else if (bus.ex_flush)
            next_pc = bus.ex_target;
        else if (bus.ex_stall)
            next_pc = bus.if_pc;
        else if (bus.id_target_taken)
            next_pc = bus.id_pc_target;
    end

    assign bus.fetch_pc  = next_pc & ~32'd3;
    assign bus.bios_en   = bus.fetch_pc[30];
    assign bus.imem_en   = ~bus.fetch_pc[30];
    assign bus.bios_addr = bus.fetch_pc[BIOS_AW+1:2];
    assign bus.imem_addr = bus.fetch_pc[IMEM_AW+1:2];

    // if_pc tracks fetch_pc so the 1-cycle memory read data always belongs to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= BOOT;
            bus.if_pc        <= RESET_PC;
            bus.if_valid     <= 1'b0;
            bus.if_fetch_cnt <= 32'd0;
        end else begin
            bus.if_pc <= bus.fetch_pc;
            case (state)
                BOOT: begin
                    state        <= RUN;
                    bus.if_valid <= 1'b1;
                end
                RUN: begin
                    if (!bus.ex_stall && !bus.ex_flush)
                        bus.if_fetch_cnt <= bus.if_fetch_cnt + 32'd1;
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage against a behavioural fetch model
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_boot;
    bit          m_valid;

    if_stage_if #(.BIOS_AW(12), .IMEM_AW(14)) bus ();

    if_stage #(.RESET_PC(RESET_PC), .BIOS_AW(12), .IMEM_AW(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_fetch();
        if (m_boot) return RESET_PC;
        if (bus.ex_flush) return (bus.ex_target / 4) * 4;
        if (bus.ex_stall) return m_pc;
        if (bus.id_target_taken) return (bus.id_pc_target / 4) * 4;
        return m_pc + 32'd4;
    endfunction

    task automatic drive(input bit stall, input bit flush, input logic [31:0] tgt,
                         input bit idt, input logic [31:0] idpc);
        bus.ex_stall        = stall;
        bus.ex_flush        = flush;
        bus.ex_target       = tgt;
        bus.id_target_taken = idt;
        bus.id_pc_target    = idpc;
        #1;
    endtask

    task automatic tick();
        logic [31:0] nf;
        bit          adv;
        nf  = exp_fetch();
        adv = m_valid && !bus.ex_stall && !bus.ex_flush;
        @(posedge clk);
        m_pc    = nf;
        if (adv) m_cnt = m_cnt + 32'd1;
        m_valid = 1'b1;
        m_boot  = 1'b0;
        #1;
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_cnt = 0; m_boot = 1'b1; m_valid = 1'b0;
    endtask

    task automatic run_until(input logic [31:0] pc);
        for (int i = 0; i < 64 && m_pc != pc; i++) begin
            drive(0, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic test_reset();
        drive(1, 1, 32'h1234_5678, 1, 32'h8765_4320);
        tests++; if (bus.if_pc !== RESET_PC) begin fails++; $display("FAIL reset_if_pc got %h exp %h", bus.if_pc, RESET_PC); end
        tests++; if (bus.if_valid !== 1'b0) begin fails++; $display("FAIL reset_if_valid got %b exp 0", bus.if_valid); end
        tests++; if (bus.if_fetch_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt got %h exp 0", bus.if_fetch_cnt); end
        tests++; if (bus.fetch_pc !== RESET_PC) begin fails++; $display("FAIL reset_fetch_pc got %h exp %h", bus.fetch_pc, RESET_PC); end
    endtask

    task automatic test_boot_seq();
        logic [31:0] exp_pc;
        logic [11:0] exp_ba;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            exp_pc = RESET_PC + 32'(4 * i);
            exp_ba = 12'(i);
            tests++; if (bus.bios_addr !== exp_ba || bus.bios_en !== 1'b1 || bus.imem_en !== 1'b0) begin
                fails++; $display("FAIL boot_bios_addr step %0d got %h/%b exp %h/1", i, bus.bios_addr, bus.bios_en, exp_ba);
            end
            tick();
            drive(0, 0, 0, 0, 0);
            tests++; if (bus.if_pc !== exp_pc || bus.if_valid !== 1'b1) begin
                fails++; $display("FAIL boot_if_pc step %0d got %h/%b exp %h/1", i, bus.if_pc, bus.if_valid, exp_pc);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] cnt0;
        run_until(32'h4000_0010);
        drive(1, 0, 0, 0, 0);
        cnt0 = bus.if_fetch_cnt;
        for (int i = 0; i < 3; i++) begin
            tests++; if (bus.bios_addr !== 12'd4) begin fails++; $display("FAIL stall_bios_addr got %h exp 4", bus.bios_addr); end
            tick();
            tests++; if (bus.if_pc !== 32'h4000_0010 || bus.if_fetch_cnt !== m_cnt) begin
                fails++; $display("FAIL stall_hold got pc %h cnt %h exp pc 40000010 cnt %h", bus.if_pc, bus.if_fetch_cnt, m_cnt);
            end
        end
        tests++; if (bus.if_fetch_cnt !== cnt0) begin fails++; $display("FAIL stall_cnt_frozen got %h exp %h", bus.if_fetch_cnt, cnt0); end
        drive(0, 0, 0, 0, 0);
        tick();
        tests++; if (bus.if_pc !== 32'h4000_0014) begin fails++; $display("FAIL stall_resume got %h exp 40000014", bus.if_pc); end
    endtask

    task automatic test_id_redirect();
        run_until(32'h4000_0020);
        drive(0, 0, 0, 1, 32'h0000_1002);
        tests++; if (bus.fetch_pc !== 32'h0000_1000 || bus.imem_en !== 1'b1 || bus.bios_en !== 1'b0 || bus.imem_addr !== 14'h400) begin
            fails++; $display("FAIL id_redirect_mem got pc %h imem_en %b bios_en %b imem_addr %h exp 1000/1/0/400",
                              bus.fetch_pc, bus.imem_en, bus.bios_en, bus.imem_addr);
        end
        tick();
        tests++; if (bus.if_pc !== 32'h0000_1000) begin fails++; $display("FAIL id_redirect_pc got %h exp 1000", bus.if_pc); end
    endtask

    task automatic test_flush_priority();
        logic [31:0] cnt0;
        cnt0 = m_cnt;
        drive(1, 1, 32'h0000_0200, 1, 32'h0000_0300);
        tick();
        tests++; if (bus.if_pc !== 32'h0000_0200) begin fails++; $display("FAIL flush_prio_pc got %h exp 200", bus.if_pc); end
        tests++; if (bus.if_fetch_cnt !== cnt0) begin fails++; $display("FAIL flush_prio_cnt got %h exp %h", bus.if_fetch_cnt, cnt0); end
        drive(1, 0, 0, 1, 32'h0000_0300);
        tick();
        tests++; if (bus.if_pc !== 32'h0000_0200) begin fails++; $display("FAIL stall_over_id got %h exp 200", bus.if_pc); end
    endtask

    task automatic test_async_reset();
        drive(0, 1, 32'h0000_0400, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++; if (bus.if_pc !== RESET_PC || bus.if_valid !== 1'b0 || bus.if_fetch_cnt !== 32'd0) begin
            fails++; $display("FAIL async_reset got pc %h valid %b cnt %h exp %h/0/0", bus.if_pc, bus.if_valid, bus.if_fetch_cnt, RESET_PC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 32'h0000_0080, 1, 32'h0000_0090);
        tests++; if (bus.fetch_pc !== RESET_PC) begin fails++; $display("FAIL boot_ignores_inputs got %h exp %h", bus.fetch_pc, RESET_PC); end
        tick();
        tests++; if (bus.if_pc !== RESET_PC || bus.if_valid !== 1'b1) begin
            fails++; $display("FAIL reboot_pc got %h/%b exp %h/1", bus.if_pc, bus.if_valid, RESET_PC);
        end
        drive(0, 0, 0, 0, 0);
        tick();
        tests++; if (bus.if_pc !== 32'h4000_0004) begin fails++; $display("FAIL reboot_seq got %h exp 40000004", bus.if_pc); end
    endtask

    task automatic test_wrap();
        drive(0, 1, 32'hFFFF_FFFF, 0, 0);
        tick();
        tests++; if (bus.if_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_flush_pc got %h exp fffffffc", bus.if_pc); end
        drive(0, 0, 0, 0, 0);
        tests++; if (bus.fetch_pc !== 32'd0 || bus.imem_en !== 1'b1) begin
            fails++; $display("FAIL wrap_fetch got %h/%b exp 0/1", bus.fetch_pc, bus.imem_en);
        end
        force bus.if_fetch_cnt = 32'hFFFF_FFFF;
        #1;
        release bus.if_fetch_cnt;
        m_cnt = 32'hFFFF_FFFF;
        tick();
        tests++; if (bus.if_pc !== 32'd0) begin fails++; $display("FAIL wrap_pc got %h exp 0", bus.if_pc); end
        tests++; if (bus.if_fetch_cnt !== 32'd0) begin fails++; $display("FAIL wrap_cnt got %h exp 0", bus.if_fetch_cnt); end
    endtask

    task automatic test_random();
        logic [31:0] ef;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 1) == 1) ? ($urandom & 32'h4000_FFFF) : $urandom,
                  $urandom_range(0, 3) == 0, $urandom);
            ef = exp_fetch();
            tests++; if (bus.fetch_pc !== ef || bus.bios_en !== ef[30] || bus.imem_en !== !ef[30]
                         || bus.bios_addr !== 12'((ef >> 2) % 4096) || bus.imem_addr !== 14'((ef >> 2) % 16384)) begin
                fails++; $display("FAIL rand_fetch cyc %0d got %h b%b/%h i%b/%h exp %h", i, bus.fetch_pc,
                                  bus.bios_en, bus.bios_addr, bus.imem_en, bus.imem_addr, ef);
            end
            tick();
            tests++; if (bus.if_pc !== m_pc || bus.if_valid !== m_valid || bus.if_fetch_cnt !== m_cnt) begin
                fails++; $display("FAIL rand_state cyc %0d got %h/%b/%h exp %h/%b/%h", i, bus.if_pc, bus.if_valid,
                                  bus.if_fetch_cnt, m_pc, m_valid, m_cnt);
            end
        end
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_boot_seq();
        test_stall();
        test_id_redirect();
        test_flush_priority();
        test_async_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
